// File: rtl/mlp_sequencer_if.sv
// Stream and core-bus bundle for mlp_sequencer: weight and sample inputs,
// result output and the mlp core's 2-bit-address register bus.
interface mlp_sequencer_if #(
  parameter int N_INPUTS  = 4,
  parameter int N_OUTPUT  = 4,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,
  parameter int WGT_WIDTH = 16
);
  logic                          wgt_valid;
  logic                          wgt_ready;
  logic [WGT_WIDTH-1:0]          wgt_data;
  logic                          wgt_layer;
  logic                          in_valid;
  logic                          in_ready;
  logic [N_INPUTS*IN_WIDTH-1:0]  in_data;
  logic                          out_valid;
  logic                          out_ready;
  logic [N_OUTPUT*OUT_WIDTH-1:0] out_data;
  logic                          m_write_en;
  logic [1:0]                    m_addr;
  logic [31:0]                   m_writedata;
  logic [31:0]                   m_readdata;

  // Sequencer side: consumes the streams, masters the core bus.
  modport master (
    input  wgt_valid, wgt_data, wgt_layer,
    output wgt_ready,
    input  in_valid, in_data,
    output in_ready,
    output out_valid, out_data,
    input  out_ready,
    output m_write_en, m_addr, m_writedata,
    input  m_readdata
  );

  // Environment side: fabric streams plus the core's register port.
  modport slave (
    output wgt_valid, wgt_data, wgt_layer,
    input  wgt_ready,
    output in_valid, in_data,
    input  in_ready,
    input  out_valid, out_data,
    output out_ready,
    input  m_write_en, m_addr, m_writedata,
    output m_readdata
  );
endinterface

// File: rtl/mlp_sequencer.sv
// Host-side sequencer for the mlp core: turns weight beats and input samples
// into register-bus transactions and returns each result vector on a stream.
module mlp_sequencer #(
  parameter int N_INPUTS  = 4,
  parameter int N_OUTPUT  = 4,
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 16,
  parameter int WGT_WIDTH = 16,
  parameter int TIMEOUT   = 1023
) (
  input  logic           clk,
  input  logic           rst,
  mlp_sequencer_if.master bus,
  output logic           busy,
  output logic           timeout_err
);

  localparam int IW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam int KW = (N_OUTPUT > 1) ? $clog2(N_OUTPUT) : 1;
  localparam int PW = $clog2(TIMEOUT + 1);
  localparam logic [IW-1:0] I_LAST = IW'(N_INPUTS - 1);
  localparam logic [KW-1:0] K_LAST = KW'(N_OUTPUT - 1);
  localparam logic [PW-1:0] P_LAST = PW'(TIMEOUT - 1);

  localparam logic [1:0] A_CTRL   = 2'd0;
  localparam logic [1:0] A_INPUT  = 2'd1;
  localparam logic [1:0] A_WEIGHT = 2'd2;
  localparam logic [1:0] A_OUTPUT = 2'd3;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    SET_LAYER = 4'd1,
    WR_WGT    = 4'd2,
    WR_IN     = 4'd3,
    RUN       = 4'd4,
    POLL      = 4'd5,
    SEL       = 4'd6,
    RD_ADDR   = 4'd7,
    RD_CAP    = 4'd8,
    ERR       = 4'd9
  } state_t;

  state_t                        state;
  logic                          cur_layer;
  logic                          pend_layer;
  logic [WGT_WIDTH-1:0]          wgt_hold;
  logic [N_INPUTS*IN_WIDTH-1:0]  in_shift;
  logic [IW-1:0]                 i;
  logic [KW-1:0]                 k;
  logic [PW-1:0]                 poll_cnt;
  logic                          out_valid;
  logic [N_OUTPUT*OUT_WIDTH-1:0] out_data;
  logic                          m_write_en;
  logic [1:0]                    m_addr;
  logic [31:0]                   m_writedata;
  logic                          unused_readdata;

  function automatic logic [31:0] ctrl_word(input logic [15:0] sel,
                                            input logic layer,
                                            input logic run);
    return {sel, 12'h000, layer, 1'b0, 1'b0, run};
  endfunction

  function automatic logic [31:0] sext_in(input logic [IN_WIDTH-1:0] x);
    return {{(32-IN_WIDTH){x[IN_WIDTH-1]}}, x};
  endfunction

  function automatic logic [31:0] zext_wgt(input logic [WGT_WIDTH-1:0] x);
    return {{(32-WGT_WIDTH){1'b0}}, x};
  endfunction

  function automatic logic [15:0] sel_field(input logic [KW-1:0] idx);
    return {{(16-KW){1'b0}}, idx};
  endfunction

  // Ready only in IDLE; a pending weight beat always beats a sample.
  assign bus.wgt_ready   = (state == IDLE);
  assign bus.in_ready    = (state == IDLE) && !bus.wgt_valid && !out_valid;
  assign busy            = (state != IDLE);
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = out_data;
  assign bus.m_write_en  = m_write_en;
  assign bus.m_addr      = m_addr;
  assign bus.m_writedata = m_writedata;
  assign unused_readdata = ^bus.m_readdata[31:OUT_WIDTH];

  // Sequencer FSM; bus outputs are loaded on the transition into each state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cur_layer   <= 1'b0;
      pend_layer  <= 1'b0;
      wgt_hold    <= '0;
      in_shift    <= '0;
      i           <= '0;
      k           <= '0;
      poll_cnt    <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      timeout_err <= 1'b0;
      m_write_en  <= 1'b0;
      m_addr      <= A_CTRL;
      m_writedata <= 32'h0000_0000;
    end else begin
      m_write_en  <= 1'b0;
      m_addr      <= A_CTRL;
      m_writedata <= 32'h0000_0000;
      if (out_valid && bus.out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (bus.wgt_valid) begin
            wgt_hold   <= bus.wgt_data;
            pend_layer <= bus.wgt_layer;
            m_write_en <= 1'b1;
            if (bus.wgt_layer == cur_layer) begin
              state       <= WR_WGT;
              m_addr      <= A_WEIGHT;
              m_writedata <= zext_wgt(bus.wgt_data);
            end else begin
              state       <= SET_LAYER;
              m_addr      <= A_CTRL;
              m_writedata <= ctrl_word(16'h0000, bus.wgt_layer, 1'b0);
            end
          end else if (bus.in_valid && !out_valid) begin
            in_shift    <= bus.in_data >> IN_WIDTH;
            i           <= '0;
            state       <= WR_IN;
            m_write_en  <= 1'b1;
            m_addr      <= A_INPUT;
            m_writedata <= sext_in(bus.in_data[IN_WIDTH-1:0]);
          end else begin
            state <= IDLE;
          end
        end
        SET_LAYER: begin
          cur_layer   <= pend_layer;
          state       <= WR_WGT;
          m_write_en  <= 1'b1;
          m_addr      <= A_WEIGHT;
          m_writedata <= zext_wgt(wgt_hold);
        end
        WR_WGT: begin
          state <= IDLE;
        end
        WR_IN: begin
          m_write_en <= 1'b1;
          if (i == I_LAST) begin
            state       <= RUN;
            m_addr      <= A_CTRL;
            m_writedata <= ctrl_word(16'h0000, cur_layer, 1'b1);
          end else begin
            i           <= i + IW'(1);
            in_shift    <= in_shift >> IN_WIDTH;
            m_addr      <= A_INPUT;
            m_writedata <= sext_in(in_shift[IN_WIDTH-1:0]);
          end
        end
        RUN: begin
          poll_cnt <= '0;
          state    <= POLL;
        end
        POLL: begin
          // The first poll returns data from the RUN write cycle, so skip it.
          if ((poll_cnt != '0) && bus.m_readdata[1]) begin
            k           <= '0;
            state       <= SEL;
            m_write_en  <= 1'b1;
            m_addr      <= A_CTRL;
            m_writedata <= ctrl_word(16'h0000, cur_layer, 1'b0);
          end else if (poll_cnt == P_LAST) begin
            state       <= ERR;
            timeout_err <= 1'b1;
          end else begin
            poll_cnt <= poll_cnt + PW'(1);
          end
        end
        SEL: begin
          state  <= RD_ADDR;
          m_addr <= A_OUTPUT;
        end
        RD_ADDR: begin
          state <= RD_CAP;
        end
        RD_CAP: begin
          out_data[k*OUT_WIDTH +: OUT_WIDTH] <= bus.m_readdata[OUT_WIDTH-1:0];
          if (k == K_LAST) begin
            out_valid <= 1'b1;
            state     <= IDLE;
          end else begin
            k           <= k + KW'(1);
            state       <= SEL;
            m_write_en  <= 1'b1;
            m_addr      <= A_CTRL;
            m_writedata <= ctrl_word(sel_field(k + KW'(1)), cur_layer, 1'b0);
          end
        end
        ERR: begin
          state       <= ERR;
          timeout_err <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mlp_sequencer.md
Name: mlp_sequencer

Overview:
- Host-side controller that drives the mlp core's 2-bit-address register bus (write_en/addr/writedata/readdata).
- Turns two valid/ready streams into fully sequenced bus transactions: weight beats, and input samples.
- Per sample: writes inputs, starts the run, polls for done, acknowledges, reads back every output, presents the result vector on an output stream.
- Sits between the fabric DMA/streaming logic and the mlp core; shares the core's clk and rst.

Parameters:
N_INPUTS, 4, inputs per sample
N_OUTPUT, 4, outputs per sample
IN_WIDTH, 16, input element width
OUT_WIDTH, 16, output element width
WGT_WIDTH, 16, weight width
TIMEOUT, 1023, max polling cycles before error

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wgt_valid  in  1  weight beat valid
wgt_ready  out  1  weight beat accepted
wgt_data  in  WGT_WIDTH  weight value
wgt_layer  in  1  0 = hidden-layer matrix, 1 = output-layer matrix
in_valid  in  1  sample valid
in_ready  out  1  sample accepted
in_data  in  N_INPUTS*IN_WIDTH  sample, element i at [i*IN_WIDTH +: IN_WIDTH]
out_valid  out  1  result valid
out_ready  in  1  result consumed
out_data  out  N_OUTPUT*OUT_WIDTH  result, element k at [k*OUT_WIDTH +: OUT_WIDTH]
busy  out  1  not in IDLE
timeout_err  out  1  sticky poll timeout
m_write_en  out  1  core write strobe
m_addr  out  2  0 = CTRL, 1 = INPUT, 2 = WEIGHT, 3 = OUTPUT
m_writedata  out  32  core write data
m_readdata  in  32  core read data

Behaviour:
- Reset:
  - rst = synchronous, active-high; clock = clk.
  - rst → state IDLE; all outputs 0; cur_layer = 0; k = 0; i = 0; poll_cnt = 0.
  - rst mid-operation aborts immediately; no further bus cycles are issued.
  - The core must receive the same rst.
- Core bus rules:
  - m_readdata is registered: the value for m_addr presented in cycle t appears in t+1.
  - CTRL word = {out_sel[31:16], 12'b0, layer[3], irq_en[2], done[1], run[0]}.
  - Every CTRL write drives irq_en = 0, done = 0, and layer = cur_layer.
- States:
  - IDLE:
    - wgt_ready = 1 and in_ready = 0 if wgt_valid; otherwise in_ready = !out_valid.
    - Weight handshake, wgt_layer == cur_layer → WR_WGT.
    - Weight handshake, wgt_layer != cur_layer → SET_LAYER.
    - Sample handshake → latch in_data, i = 0 → WR_IN.
    - Weights win when both streams are valid.
  - SET_LAYER: write CTRL = wgt_layer<<3; cur_layer <= wgt_layer → WR_WGT.
  - WR_WGT: write addr 2, data = zero-extended latched weight → IDLE. One weight per beat; the core auto-advances row/col.
  - WR_IN: write addr 1, data = sign-extended element i; i++; after element N_INPUTS-1 → RUN.
  - RUN: write CTRL with run = 1 (0x1, or 0x9 when cur_layer = 1); poll_cnt = 0 → POLL.
  - POLL:
    - m_addr = 0, no write; poll_cnt++.
    - From the 2nd POLL cycle on, if m_readdata[1] = 1 → SEL with k = 0.
    - If poll_cnt reaches TIMEOUT → ERR.
  - SEL:
    - Write CTRL with out_sel = k (e.g. 0x00010000 for k = 1).
    - The first SEL (done still set) also acts as the core's restart acknowledge.
    - → RD_ADDR.
  - RD_ADDR: m_addr = 3, no write → RD_CAP.
  - RD_CAP:
    - Capture m_readdata[OUT_WIDTH-1:0] into out_data slot k.
    - k == N_OUTPUT-1 → out_valid <= 1 → IDLE; else k++ → SEL.
  - ERR: timeout_err = 1; busy = 1; both ready signals = 0. Exit only via rst.
- Output stream:
  - out_valid holds, with out_data stable, until out_ready.
  - out_valid and out_ready in the same cycle clears out_valid.
  - No new sample is accepted while out_valid = 1 (single result buffer).
- Idle bus: when no write, m_write_en = 0 and m_writedata = 0. In IDLE, m_addr = 0.
- Latency: sample accept → out_valid = 1 + N_INPUTS + 1 + poll cycles + 3*N_OUTPUT cycles.
- Core restart spacing: the core returns to its IDLE one cycle after the acknowledge. The ≥2 cycles from the last SEL to the next WR_IN guarantee input and weight writes land in core IDLE.

Test Plan:
- Reset: assert rst during WR_IN → next cycle m_write_en = 0, busy = 0, out_valid = 0, cur_layer = 0.
- Weights: beats (layer 0, 0x0011), (layer 0, 0x0022), (layer 1, 0x0033) → bus trace: W2 0x11; W2 0x22; W0 0x00000008; W2 0x33. wgt_ready pulses once per beat.
- Sample:
  - Stimulus: in_data = {4, 3, 2, 1}; core model sets done 20 cycles after run; outputs 0x0005, 0x0006, 0x0007, 0x0008.
  - Bus trace: W1 1; W1 2; W1 3; W1 4; W0 0x1; polls; W0 0x00000000; R3; W0 0x00010000; R3; … up to out_sel 3.
  - Result: out_data = {8, 7, 6, 5}; out_valid = 1.
- Backpressure: out_ready = 0 for 10 cycles with in_valid = 1 → in_ready = 0 and out_data stable; out_ready = 1 → next sample accepted the following cycle.
- Timeout: TIMEOUT = 15, done never set → timeout_err = 1 after 15 POLL cycles; in_ready and wgt_ready stay 0 until rst.
- Arbitration: wgt_valid and in_valid both 1 in IDLE → weight written first, then the sample proceeds. After a layer-1 weight, the run write is 0x9.
